// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts single-shot 256-bit line read/write requests
// from the L1 cache into 4-beat, 64-bit bursts toward main memory, then
// returns a one-cycle resp_o pulse to the cache.
// Optional build macro CACHELINE_ADAPTOR_WATCHDOG_EN adds a beat watchdog
// that aborts a stalled burst, sets a sticky err_o and still answers the cache.
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5,
  parameter int timeout  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i,
  output logic               err_o
);

  localparam int BEATS = s_line / s_burst;
  localparam int KW    = $clog2(BEATS);
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [s_line-1:0]   buf_q, buf_d;
  logic [s_line-1:0]   line_o_q, line_o_d;
  logic [s_burst-1:0]  burst_o_q, burst_o_d;
  logic [31:0]         address_o_q, address_o_d;
  logic                resp_o_q, resp_o_d;
  logic                read_o_q, read_o_d;
  logic                write_o_q, write_o_d;
  logic [31:0]         addr_aligned;

  assign addr_aligned = {address_i[31:s_offset], {s_offset{1'b0}}};

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  localparam int WDW = $clog2(timeout + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(timeout - 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    buf_d       = buf_q;
    line_o_d    = line_o_q;
    burst_o_d   = burst_o_q;
    address_o_d = address_o_q;
    resp_o_d    = 1'b0;
    read_o_d    = read_o_q;
    write_o_d   = write_o_q;
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    wd_d        = '0;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (write_i) begin
          // beat 0 goes out immediately; the rest wait in the shift buffer
          burst_o_d   = line_i[s_burst-1:0];
          buf_d       = line_i >> s_burst;
          address_o_d = addr_aligned;
          write_o_d   = 1'b1;
          state_d     = WRITE;
        end else if (read_i) begin
          address_o_d = addr_aligned;
          read_o_d    = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_o_d[s_burst*k_q +: s_burst] = burst_i;
          if (k_q == K_LAST) begin
            k_d      = '0;
            read_o_d = 1'b0;
            resp_o_d = 1'b1;
            state_d  = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          burst_o_d = buf_q[s_burst-1:0];
          buf_d     = buf_q >> s_burst;
          if (k_q == K_LAST) begin
            k_d       = '0;
            write_o_d = 1'b0;
            resp_o_d  = 1'b1;
            state_d   = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      // Turnaround cycle: requests are deliberately not sampled here
      default: state_d = IDLE;
    endcase
`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    if ((state_q == READ || state_q == WRITE) && !resp_i) begin
      if (wd_q == WD_LAST) begin
        read_o_d  = 1'b0;
        write_o_d = 1'b0;
        resp_o_d  = 1'b1;
        err_d     = 1'b1;
        k_d       = '0;
        state_d   = DONE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      buf_q       <= '0;
      line_o_q    <= '0;
      burst_o_q   <= '0;
      address_o_q <= '0;
      resp_o_q    <= 1'b0;
      read_o_q    <= 1'b0;
      write_o_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      line_o_q    <= line_o_d;
      burst_o_q   <= burst_o_d;
      address_o_q <= address_o_d;
      resp_o_q    <= resp_o_d;
      read_o_q    <= read_o_d;
      write_o_q   <= write_o_d;
    end
  end

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign line_o    = line_o_q;
  assign burst_o   = burst_o_q;
  assign address_o = address_o_q;
  assign resp_o    = resp_o_q;
  assign read_o    = read_o_q;
  assign write_o   = write_o_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a queue-based scoreboard.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i, err_o;

  int checks = 0;
  int errors = 0;

  logic [255:0] lq[$];   // expected read lines
  logic [63:0]  rq[$];   // beats the memory model returns
  logic [63:0]  wq[$];   // expected write beats
  logic [255:0] last_line;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .resp_i(resp_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side: pat bit i = resp_i in cycle i. With fin set, the burst is
  // expected to complete and resp_o must be high once the loop ends.
  task automatic serve(input logic [31:0] pat, input int n, input bit is_wr, input bit fin);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      chk(is_wr ? "write_o_busy" : "read_o_busy", is_wr ? write_o : read_o, 1'b1);
      chk("resp_o_busy", resp_o, 1'b0);
      if (pat[i]) begin
        if (is_wr) begin
          e = wq.pop_front();
          chk("burst_o", burst_o, e);
        end else begin
          burst_i = rq.pop_front();
        end
        resp_i = 1'b1;
      end else begin
        burst_i = {$urandom, $urandom};
        resp_i  = 1'b0;
      end
      tick();
    end
    resp_i = 1'b0;
    if (fin) begin
      chk("resp_o_done", resp_o, 1'b1);
      chk("read_o_done", read_o, 1'b0);
      chk("write_o_done", write_o, 1'b0);
      if (!is_wr) begin
        last_line = lq.pop_front();
        chk("line_o", line_o, last_line);
      end
    end
  endtask

  task automatic start_read(input logic [31:0] a, input logic [63:0] b0, b1, b2, b3);
    read_i = 1'b1;
    address_i = a;
    rq.push_back(b0); rq.push_back(b1); rq.push_back(b2); rq.push_back(b3);
    lq.push_back({b3, b2, b1, b0});
    tick();
    address_i = 32'hdead_beef;   // must not disturb the accepted request
    chk("read_o_rise", read_o, 1'b1);
    chk("address_o_rd", address_o, a & 32'hffff_ffe0);
  endtask

  initial begin
    logic [255:0] wl;
    int n;
    rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0; last_line = '0;
    #12;
    chk("rst_line_o", line_o, '0);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_address_o", address_o, '0);
    chk("rst_rw_o", {read_o, write_o}, 2'b00);
    chk("rst_err_o", err_o, 1'b0);
    rst = 1'b1;
    tick();

    // resp_i in IDLE must be ignored
    resp_i = 1'b1; burst_i = 64'hbad;
    tick();
    resp_i = 1'b0;
    chk("idle_resp_ignored", {resp_o, read_o, write_o}, 3'b000);

    // Basic read
    start_read(32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
    serve(32'hf, 4, 1'b0, 1'b1);
    read_i = 1'b0;
    tick();
    chk("resp_o_one_cycle", resp_o, 1'b0);

    // Basic write, line_o must stay unchanged
    wl = {64'hd3d3_0003_3333_d3d3, 64'hd2d2_0002_2222_d2d2,
          64'hd1d1_0001_1111_d1d1, 64'hd0d0_0000_0000_d0d0};
    write_i = 1'b1; line_i = wl; address_i = 32'habcd_ef7f;
    for (int i = 0; i < 4; i++) wq.push_back(wl[64*i +: 64]);
    tick();
    line_i = '1; address_i = '0;
    chk("write_o_rise", write_o, 1'b1);
    chk("address_o_wr", address_o, 32'habcd_ef60);
    serve(32'hf, 4, 1'b1, 1'b1);
    chk("line_o_after_wr", line_o, last_line);
    write_i = 1'b0;
    tick();
    chk("resp_o_one_cycle_wr", resp_o, 1'b0);

    // Gapped read beats: 1,0,0,1,0,1,1
    start_read(32'h8000_0040, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
               64'h5555_aaaa_5555_aaaa, 64'h0f0f_f0f0_0f0f_f0f0);
    serve(32'b1101001, 7, 1'b0, 1'b1);
    read_i = 1'b0;
    tick();

    // Priority: write wins, read held through resp_o restarts 2 cycles later
    wl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    write_i = 1'b1; read_i = 1'b1; line_i = wl; address_i = 32'h0000_2000;
    for (int i = 0; i < 4; i++) wq.push_back(wl[64*i +: 64]);
    tick();
    write_i = 1'b0;
    chk("prio_rw", {read_o, write_o}, 2'b01);
    serve(32'hf, 4, 1'b1, 1'b1);
    rq.push_back(64'h1); rq.push_back(64'h2); rq.push_back(64'h3); rq.push_back(64'h4);
    lq.push_back({64'h4, 64'h3, 64'h2, 64'h1});
    tick();
    chk("turnaround_idle", {resp_o, read_o}, 2'b00);
    tick();
    chk("turnaround_read", read_o, 1'b1);
    chk("turnaround_addr", address_o, 32'h0000_2000);
    serve(32'hf, 4, 1'b0, 1'b1);
    read_i = 1'b0;
    tick();

    // Reset mid-burst after 2 beats
    start_read(32'h0000_0300, 64'haa, 64'hbb, 64'hcc, 64'hdd);
    serve(32'h3, 2, 1'b0, 1'b0);
    resp_i = 1'b1; burst_i = 64'hcc;
    #2 rst = 1'b0;
    #1;
    chk("midrst_line_o", line_o, '0);
    chk("midrst_outs", {resp_o, read_o, write_o, err_o}, 4'b0000);
    chk("midrst_addr", address_o, '0);
    lq.delete(); rq.delete();
    read_i = 1'b0; resp_i = 1'b0;
    tick();
    chk("midrst_no_resp", resp_o, 1'b0);
    #2 rst = 1'b1;
    tick();
    start_read(32'h0000_07ff, 64'h77, 64'h88, 64'h99, 64'haa);
    serve(32'hf, 4, 1'b0, 1'b1);
    read_i = 1'b0;
    tick();

`ifdef CACHELINE_ADAPTOR_WATCHDOG_EN
    start_read(32'h0000_1000, 64'h0, 64'h0, 64'h0, 64'h0);
    read_i = 1'b0;
    n = 0;
    while (!resp_o && n < 100) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 64);
    chk("wd_resp_o", resp_o, 1'b1);
    chk("wd_read_o", read_o, 1'b0);
    chk("wd_err_o", err_o, 1'b1);
    tick();
    chk("wd_err_sticky", err_o, 1'b1);
`else
    n = 0;
    chk("err_o_tied", err_o, {255'b0, n[0]});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
